// File: rtl/conv_layer_input_interface_pkg.sv
// Shared definitions for the conv layer input interface.
//   - CMD_* : one-cycle commands issued by the conv layer controller
//   - ACK_* : one-cycle completion acks returned to the controller
//   - TOTAL_WEIGHT / TOTAL_SHIFT : window rows per position and window positions per band,
//     given for the default configuration (KERNEL_SIZE=3, IMG_W=6); the controller uses the
//     same values.
//   - state_e : state encoding of the input interface FSM
package conv_layer_input_interface_pkg;

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  localparam logic [1:0] ACK_IDLE        = 2'd0;
  localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
  localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

  localparam int unsigned TOTAL_WEIGHT = 3;
  localparam int unsigned TOTAL_SHIFT  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRELOAD,
    S_LOAD
  } state_e;

endpackage

// File: rtl/conv_window_buffer.sv
// KERNEL_SIZE x KERNEL_SIZE pixel window register.
//   clk, rst_n : clock, asynchronous active-low reset (window cleared to 0)
//   shift_en   : shift every row left by one column (win[r][c] <= win[r][c+1])
//   wr_en      : write wr_data into win[wr_row][wr_col] (ignored while shift_en is high)
//   rd_row     : row select for rd_data
//   rd_data    : selected row, pixel c at [c*DATA_WIDTH +: DATA_WIDTH] (combinational)
module conv_window_buffer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              shift_en,
  input  logic                              wr_en,
  input  logic [IDX_W-1:0]                  wr_row,
  input  logic [IDX_W-1:0]                  wr_col,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic [IDX_W-1:0]                  rd_row,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] win_q [KERNEL_SIZE][KERNEL_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      // Last column keeps its old pixel until the new column is fetched into it.
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
    end else if (wr_en) begin
      win_q[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < KERNEL_SIZE; c++) begin
      rd_data[c*DATA_WIDTH +: DATA_WIDTH] = win_q[rd_row][c];
    end
  end

endmodule

// File: rtl/conv_layer_input_interface.sv
// Input-side data mover for the convolution layer.
// Executes PRELOAD / SHIFT / LOAD commands from the conv layer controller, fetches pixels
// from a synchronous image RAM (1-cycle read latency) into a KxK window and presents one
// window row per SHIFT to the kernel array.
//   clk, rst_n           : clock, asynchronous active-low reset
//   input_interface_cmd  : CMD_* one-cycle command pulses
//   input_interface_ack  : ACK_* one-cycle completion pulses (registered)
//   ram_rd_en, ram_addr  : RAM read strobe and row-major pixel address
//   ram_data             : RAM read data, valid the cycle after ram_rd_en
//   row_data, row_valid  : current window row and its one-cycle valid
//   frame_done           : pulses with the last SHIFT ack of the frame
//   protocol_err         : sticky illegal-command flag, cleared only by reset
// KERNEL_SIZE must be at least 2.
module conv_layer_input_interface
  import conv_layer_input_interface_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IMG_W       = 6,
  parameter int unsigned IMG_H       = 6,
  parameter int unsigned ADDR_WIDTH  = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        input_interface_cmd,
  output logic [1:0]                        input_interface_ack,
  output logic                              ram_rd_en,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  input  logic [DATA_WIDTH-1:0]             ram_data,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] row_data,
  output logic                              row_valid,
  output logic                              frame_done,
  output logic                              protocol_err
);

  localparam int unsigned KW = $clog2(KERNEL_SIZE);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned BW = $clog2(IMG_H);
  localparam int unsigned NW = $clog2(KERNEL_SIZE * KERNEL_SIZE + 1);

  localparam logic [KW-1:0] KLast      = KW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] ColLast    = CW'(IMG_W - KERNEL_SIZE);
  localparam logic [BW-1:0] BandLast   = BW'(IMG_H - KERNEL_SIZE);
  localparam logic [NW-1:0] PreloadCnt = NW'(KERNEL_SIZE * KERNEL_SIZE);
  localparam logic [NW-1:0] LoadCnt    = NW'(KERNEL_SIZE);

  state_e          state_q;
  logic [BW-1:0]   band_pos_q;
  logic [CW-1:0]   col_pos_q;
  logic [KW-1:0]   row_idx_q;
  logic            first_q;
  // Next pixel to request from the RAM and how many have been requested.
  logic [KW-1:0]   iss_row_q;
  logic [KW-1:0]   iss_col_q;
  logic [NW-1:0]   iss_cnt_q;
  // Window slot the next returning pixel lands in.
  logic [KW-1:0]   cap_row_q;
  logic [KW-1:0]   cap_col_q;
  // ram_data carries a requested pixel this cycle.
  logic            rd_pend_q;

  logic            acc_preload;
  logic            acc_shift;
  logic            acc_load;
  logic            cmd_err;
  logic [BW-1:0]   band_nxt;

  logic            buf_shift;
  logic            buf_wr;
  logic [KW-1:0]   buf_wr_col;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] buf_rd_data;

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input int unsigned row,
                                                     input int unsigned col);
    return ADDR_WIDTH'(row * IMG_W + col);
  endfunction

  always_comb begin
    acc_preload = (state_q == S_IDLE) && (input_interface_cmd == CMD_PRELOAD);
    acc_shift   = (state_q == S_IDLE) && (input_interface_cmd == CMD_SHIFT) && !first_q;
    acc_load    = (state_q == S_IDLE) && (input_interface_cmd == CMD_LOAD) && !first_q &&
                  (col_pos_q != ColLast);
    cmd_err     = (input_interface_cmd != CMD_IDLE) && !(acc_preload || acc_shift || acc_load);

    // The first PRELOAD after reset starts at band 0; later ones advance and wrap.
    if (first_q || (band_pos_q == BandLast)) begin
      band_nxt = '0;
    end else begin
      band_nxt = band_pos_q + 1'b1;
    end
  end

  always_comb begin
    buf_shift  = acc_load;
    buf_wr     = (state_q != S_IDLE) && rd_pend_q;
    buf_wr_col = (state_q == S_LOAD) ? KLast : cap_col_q;
  end

  conv_window_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .IDX_W       (KW)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (buf_shift),
    .wr_en    (buf_wr),
    .wr_row   (cap_row_q),
    .wr_col   (buf_wr_col),
    .wr_data  (ram_data),
    .rd_row   (row_idx_q),
    .rd_data  (buf_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= S_IDLE;
      band_pos_q          <= '0;
      col_pos_q           <= '0;
      row_idx_q           <= '0;
      first_q             <= 1'b1;
      iss_row_q           <= '0;
      iss_col_q           <= '0;
      iss_cnt_q           <= '0;
      cap_row_q           <= '0;
      cap_col_q           <= '0;
      rd_pend_q           <= 1'b0;
      input_interface_ack <= ACK_IDLE;
      ram_rd_en           <= 1'b0;
      ram_addr            <= '0;
      row_data            <= '0;
      row_valid           <= 1'b0;
      frame_done          <= 1'b0;
      protocol_err        <= 1'b0;
    end else begin
      input_interface_ack <= ACK_IDLE;
      row_valid           <= 1'b0;
      frame_done          <= 1'b0;
      ram_rd_en           <= 1'b0;
      rd_pend_q           <= ram_rd_en;

      if (cmd_err) begin
        protocol_err <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (acc_preload) begin
            band_pos_q <= band_nxt;
            first_q    <= 1'b0;
            col_pos_q  <= '0;
            row_idx_q  <= '0;
            ram_rd_en  <= 1'b1;
            ram_addr   <= pix_addr(32'(band_nxt), 0);
            iss_cnt_q  <= NW'(1);
            iss_row_q  <= '0;
            iss_col_q  <= KW'(1);
            cap_row_q  <= '0;
            cap_col_q  <= '0;
            state_q    <= S_PRELOAD;
          end else if (acc_shift) begin
            row_data            <= buf_rd_data;
            row_valid           <= 1'b1;
            input_interface_ack <= ACK_SHIFT_FIN;
            frame_done          <= (row_idx_q == KLast) && (col_pos_q == ColLast) &&
                                   (band_pos_q == BandLast);
            row_idx_q           <= (row_idx_q == KLast) ? '0 : row_idx_q + 1'b1;
          end else if (acc_load) begin
            // New rightmost column is col_pos+1+KERNEL_SIZE-1.
            col_pos_q <= col_pos_q + 1'b1;
            ram_rd_en <= 1'b1;
            ram_addr  <= pix_addr(32'(band_pos_q), 32'(col_pos_q) + KERNEL_SIZE);
            iss_cnt_q <= NW'(1);
            iss_row_q <= KW'(1);
            cap_row_q <= '0;
            state_q   <= S_LOAD;
          end
        end

        S_PRELOAD: begin
          if (iss_cnt_q != PreloadCnt) begin
            ram_rd_en <= 1'b1;
            ram_addr  <= pix_addr(32'(band_pos_q) + 32'(iss_row_q), 32'(iss_col_q));
            iss_cnt_q <= iss_cnt_q + 1'b1;
            if (iss_col_q == KLast) begin
              iss_col_q <= '0;
              iss_row_q <= iss_row_q + 1'b1;
            end else begin
              iss_col_q <= iss_col_q + 1'b1;
            end
          end
          if (rd_pend_q) begin
            if (cap_col_q == KLast) begin
              cap_col_q <= '0;
              cap_row_q <= cap_row_q + 1'b1;
              if (cap_row_q == KLast) begin
                input_interface_ack <= ACK_PRELOAD_FIN;
                state_q             <= S_IDLE;
              end
            end else begin
              cap_col_q <= cap_col_q + 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (iss_cnt_q != LoadCnt) begin
            ram_rd_en <= 1'b1;
            ram_addr  <= pix_addr(32'(band_pos_q) + 32'(iss_row_q),
                                  32'(col_pos_q) + KERNEL_SIZE - 1);
            iss_cnt_q <= iss_cnt_q + 1'b1;
            iss_row_q <= iss_row_q + 1'b1;
          end
          if (rd_pend_q) begin
            if (cap_row_q == KLast) begin
              input_interface_ack <= ACK_LOAD_FIN;
              state_q             <= S_IDLE;
            end else begin
              cap_row_q <= cap_row_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_input_interface.sv
// Scoreboard bench: each command pushes its expected RAM reads and acks (with the cycle they
// must appear in); a negedge monitor pops and compares them as the DUT produces them.
// The RAM model returns the read address as data.
module tb_conv_layer_input_interface;
  import conv_layer_input_interface_pkg::*;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      cmd = CMD_IDLE;
  logic [1:0]      ack;
  logic            rd_en;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   ram_data = '0;
  logic [K*DW-1:0] row_data;
  logic            row_valid;
  logic            frame_done;
  logic            protocol_err;

  conv_layer_input_interface #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IMG_W       (W),
    .IMG_H       (H),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .input_interface_cmd (cmd),
    .input_interface_ack (ack),
    .ram_rd_en           (rd_en),
    .ram_addr            (addr),
    .ram_data            (ram_data),
    .row_data            (row_data),
    .row_valid           (row_valid),
    .frame_done          (frame_done),
    .protocol_err        (protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en) ram_data <= DW'(addr);

  typedef struct {
    logic [1:0]      code;
    int              cyc;
    logic [K*DW-1:0] row;
    logic            fd;
  } ack_t;
  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } rd_t;

  ack_t ack_q[$];
  rd_t  rd_q[$];
  ack_t ae;
  rd_t  re;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_count = 0;

  int m_band = 0;
  int m_col  = 0;
  int m_row  = 0;
  bit m_first = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [K*DW-1:0] exp_row(input int band, input int col, input int r);
    logic [K*DW-1:0] v;
    for (int c = 0; c < K; c++) v[c*DW +: DW] = DW'((band + r) * W + col + c);
    return v;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          check("unexp_rd_en", 64'(rd_en), 64'(0));
        end else begin
          re = rd_q.pop_front();
          check("rd_addr", 64'(addr), 64'(re.addr));
          check("rd_cycle", 64'(cyc), 64'(re.cyc));
        end
      end
      if (frame_done) fd_count++;
      if (ack != ACK_IDLE) begin
        if (ack_q.size() == 0) begin
          check("unexp_ack", 64'(ack), 64'(ACK_IDLE));
        end else begin
          ae = ack_q.pop_front();
          check("ack_code", 64'(ack), 64'(ae.code));
          check("ack_cycle", 64'(cyc), 64'(ae.cyc));
          check("row_valid", 64'(row_valid), 64'(ae.code == ACK_SHIFT_FIN));
          check("frame_done", 64'(frame_done), 64'(ae.fd));
          if (ae.code == ACK_SHIFT_FIN) check("row_data", 64'(row_data), 64'(ae.row));
        end
      end else begin
        if (row_valid) check("stray_row_valid", 64'(row_valid), 64'(0));
        if (frame_done) check("stray_frame_done", 64'(frame_done), 64'(0));
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_ack", 64'(ack), 64'(ACK_IDLE));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_row_data", 64'(row_data), 64'(0));
    check("rst_row_valid", 64'(row_valid), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_protocol_err", 64'(protocol_err), 64'(0));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rd_q_empty"}, 64'(rd_q.size()), 64'(0));
    check({tag, "_ack_q_empty"}, 64'(ack_q.size()), 64'(0));
  endtask

  // Called at a negedge; returns at a negedge. inj_shift drives an illegal SHIFT mid-PRELOAD.
  task automatic do_preload(input bit inj_shift);
    int c0;
    ack_t a;
    rd_t r;
    c0 = cyc;
    cmd = CMD_PRELOAD;
    m_band = m_first ? 0 : ((m_band == H - K) ? 0 : m_band + 1);
    m_first = 1'b0;
    m_col = 0;
    m_row = 0;
    for (int i = 0; i < K * K; i++) begin
      r.addr = AW'((m_band + i / K) * W + i % K);
      r.cyc  = c0 + 1 + i;
      rd_q.push_back(r);
    end
    a.code = ACK_PRELOAD_FIN; a.cyc = c0 + K * K + 2; a.row = '0; a.fd = 1'b0;
    ack_q.push_back(a);
    for (int k = 1; k <= K * K + 3; k++) begin
      @(negedge clk);
      cmd = (inj_shift && k == 3) ? CMD_SHIFT : CMD_IDLE;
    end
    check_drained("preload");
  endtask

  task automatic do_load();
    int c0;
    ack_t a;
    rd_t r;
    c0 = cyc;
    cmd = CMD_LOAD;
    m_col++;
    for (int i = 0; i < K; i++) begin
      r.addr = AW'((m_band + i) * W + m_col + K - 1);
      r.cyc  = c0 + 1 + i;
      rd_q.push_back(r);
    end
    a.code = ACK_LOAD_FIN; a.cyc = c0 + K + 2; a.row = '0; a.fd = 1'b0;
    ack_q.push_back(a);
    for (int k = 1; k <= K + 3; k++) begin
      @(negedge clk);
      cmd = CMD_IDLE;
    end
    check_drained("load");
  endtask

  task automatic do_shifts(input int n);
    ack_t a;
    for (int i = 0; i < n; i++) begin
      cmd = CMD_SHIFT;
      a.code = ACK_SHIFT_FIN;
      a.cyc  = cyc + 1;
      a.row  = exp_row(m_band, m_col, m_row);
      a.fd   = (m_row == K - 1) && (m_col == W - K) && (m_band == H - K);
      ack_q.push_back(a);
      m_row = (m_row == K - 1) ? 0 : m_row + 1;
      @(negedge clk);
    end
    cmd = CMD_IDLE;
    repeat (2) @(negedge clk);
    check_drained("shift");
  endtask

  task automatic do_err_cmd(input logic [1:0] c, input string tag);
    cmd = c;
    @(negedge clk);
    cmd = CMD_IDLE;
    repeat (3) @(negedge clk);
    check({tag, "_protocol_err"}, 64'(protocol_err), 64'(1));
    check_drained(tag);
  endtask

  initial begin
    int c0;
    rd_t r;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals();

    // Commands before the first PRELOAD are illegal.
    do_err_cmd(CMD_SHIFT, "shift_before_preload");
    do_err_cmd(CMD_LOAD, "load_before_preload");

    // Reset asserted in cycle 5 of a PRELOAD: four reads seen, no ack, everything cleared.
    c0 = cyc;
    cmd = CMD_PRELOAD;
    for (int i = 0; i < 4; i++) begin
      r.addr = AW'((i / K) * W + i % K);
      r.cyc  = c0 + 1 + i;
      rd_q.push_back(r);
    end
    @(negedge clk);
    cmd = CMD_IDLE;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    m_first = 1'b1; m_band = 0; m_col = 0; m_row = 0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    check_drained("abort");

    // Full frame: 4 bands x 4 window positions, 3 SHIFTs each.
    for (int b = 0; b < H - K + 1; b++) begin
      do_preload(1'b0);
      do_shifts(K);
      for (int p = 1; p < W - K + 1; p++) begin
        do_load();
        do_shifts(K);
      end
    end
    check("frame_done_count", 64'(fd_count), 64'(1));
    check("frame_protocol_err", 64'(protocol_err), 64'(0));

    // Fifth PRELOAD wraps to band 0; an illegal SHIFT during it is ignored.
    do_preload(1'b1);
    check("shift_in_preload_err", 64'(protocol_err), 64'(1));
    do_shifts(K);

    // Walk to the last column, then an extra LOAD is illegal.
    for (int p = 1; p < W - K + 1; p++) do_load();
    do_err_cmd(CMD_LOAD, "load_at_last_col");
    do_shifts(K);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
